// File: rtl/conversor_bcd_display_pkg.sv
// Shared definitions for the BCD-to-display converter: FSM states, segment
// patterns, iteration count and the double-dabble nibble adjust.
package conversor_bcd_display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int N_ITER = 9;

  // Segment patterns, bit order g..a, active-high
  localparam logic [6:0] SEG_0      = 7'h3F;
  localparam logic [6:0] SEG_1      = 7'h06;
  localparam logic [6:0] SEG_2      = 7'h5B;
  localparam logic [6:0] SEG_3      = 7'h4F;
  localparam logic [6:0] SEG_4      = 7'h66;
  localparam logic [6:0] SEG_5      = 7'h6D;
  localparam logic [6:0] SEG_6      = 7'h7D;
  localparam logic [6:0] SEG_7      = 7'h07;
  localparam logic [6:0] SEG_8      = 7'h7F;
  localparam logic [6:0] SEG_9      = 7'h6F;
  localparam logic [6:0] SEG_BRANCO = 7'h00;
  localparam logic [6:0] SEG_MENOS  = 7'h40;

  // Any code above 9 decodes to blank, so this doubles as a blanking code
  localparam logic [3:0] BCD_BRANCO = 4'hF;

  function automatic logic [3:0] soma3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/conversor_bcd_display_decodificador_7seg.sv
// Combinational BCD to seven-segment decoder (g..a, active-high).
// Codes 10..15 produce a blank digit.
module decodificador_7seg
  import conversor_bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BRANCO;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BRANCO;
    endcase
  end

endmodule

// File: rtl/conversor_bcd_display.sv
// Converts a 9-bit adder/subtractor result to sign + three BCD digits with a
// sequential double-dabble engine and scans them onto a 4-digit display.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OCIOSO   | idle; inicio captures magnitude and sign
// CONVERTE | one adjust+shift per cycle, 9 cycles; last one latches digits
// FIM      | pronto pulse, back to OCIOSO
module conversor_bcd_display
  import conversor_bcd_display_pkg::*;
#(
  parameter int DIV_SCAN = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [8:0] valor,
  input  logic       com_sinal,
  output logic       ocupado,
  output logic       pronto,
  output logic       negativo,
  output logic [3:0] centena,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic [6:0] segmentos,
  output logic [3:0] anodos
);

  localparam int SCAN_W = $clog2(DIV_SCAN);

  estado_t estado, estado_prox;

  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  iter_q;
  logic        sinal_q;

  logic        captura, desloca, trava;
  logic [8:0]  magnitude;
  logic [11:0] bcd_ajust;
  logic [11:0] bcd_desl;
  logic [8:0]  bin_desl;
  logic        ultima;

  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        idx_q;
  logic [3:0]        nib_sel;
  logic [6:0]        seg_dec;

  assign magnitude = (com_sinal && valor[8]) ? (~valor + 9'd1) : valor;

  assign bcd_ajust = {soma3(bcd_q[11:8]), soma3(bcd_q[7:4]), soma3(bcd_q[3:0])};
  assign {bcd_desl, bin_desl} = {bcd_ajust[10:0], bin_q, 1'b0};
  assign ultima = (iter_q == 4'(N_ITER - 1));

  always_comb begin
    estado_prox = estado;
    captura     = 1'b0;
    desloca     = 1'b0;
    trava       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          captura     = 1'b1;
          estado_prox = CONVERTE;
        end
      end
      CONVERTE: begin
        desloca = 1'b1;
        if (ultima) begin
          trava       = 1'b1;
          estado_prox = FIM;
        end
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= OCIOSO;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      sinal_q  <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      negativo <= 1'b0;
      centena  <= '0;
      dezena   <= '0;
      unidade  <= '0;
    end else begin
      estado  <= estado_prox;
      ocupado <= (estado_prox == CONVERTE);
      pronto  <= trava;
      if (captura) begin
        bin_q   <= magnitude;
        bcd_q   <= '0;
        iter_q  <= '0;
        sinal_q <= com_sinal & valor[8];
      end
      if (desloca) begin
        bcd_q  <= bcd_desl;
        bin_q  <= bin_desl;
        iter_q <= iter_q + 4'd1;
      end
      // Displayed digits only change here, so the scan never sees partial sums
      if (trava) begin
        centena  <= bcd_desl[11:8];
        dezena   <= bcd_desl[7:4];
        unidade  <= bcd_desl[3:0];
        negativo <= sinal_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_W'(DIV_SCAN - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Leading-zero blanking on tens/hundreds; units always lit
  always_comb begin
    nib_sel = BCD_BRANCO;
    case (idx_q)
      2'd0:    nib_sel = unidade;
      2'd1:    nib_sel = (centena == 4'd0 && dezena == 4'd0) ? BCD_BRANCO : dezena;
      2'd2:    nib_sel = (centena == 4'd0) ? BCD_BRANCO : centena;
      default: nib_sel = BCD_BRANCO;
    endcase
  end

  decodificador_7seg u_dec (
    .bcd (nib_sel),
    .seg (seg_dec)
  );

  assign segmentos = (idx_q == 2'd3) ? (negativo ? SEG_MENOS : SEG_BRANCO) : seg_dec;
  assign anodos    = ~(4'b0001 << idx_q);

endmodule
